ex_mdu: RTL
===========

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width (legal values 16, 32, 64).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(XLEN)+1, giving the iteration counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation, sampled only in IDLE.
REQ-006 The block SHALL have port funct3, input, 3 bits: RV M-extension op (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 The block SHALL have ports dataA and dataB, inputs, XLEN bits each: rs1 and rs2 operands, sampled with start.
REQ-008 The block SHALL have port flush, input, 1 bit: abort any operation in progress.
REQ-009 The block SHALL have port busy, output, 1 bit: high in CALC and DONE.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-011 The block SHALL have port result, output, XLEN bits: last completed result.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE.
REQ-013 IDLE with start=1 and flush=0 SHALL capture funct3 and operands, clear the counter, and go to CALC; the special cases are the exception (REQ-019).
REQ-014 CALC SHALL perform one radix-2 step per cycle for exactly XLEN cycles, then go to DONE.
REQ-015 DONE SHALL assert done and update result for exactly one cycle, then return to IDLE.
REQ-016 Normal-case latency SHALL be: done high on the (XLEN+1)th rising edge after the edge sampling start (33 cycles for XLEN=32).
REQ-017 Multiply SHALL form a 2*XLEN product after sign handling:
- MUL: low XLEN bits.
- MULH: high bits, signed x signed.
- MULHSU: high bits, signed dataA x unsigned dataB.
- MULHU: high bits, unsigned x unsigned.
REQ-018 Divide SHALL use restoring division on magnitudes with sign correction:
- Quotient truncates toward zero.
- Remainder sign equals dividend sign.
REQ-019 The divide special cases SHALL go IDLE->DONE directly, with done on the first edge after start:
- Divisor zero: DIV/DIVU result all-ones; REM/REMU result equals dataA.
- Signed overflow (DIV/REM with dataA = most-negative and dataB = -1): DIV result equals dataA; REM result 0.
REQ-020 A start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-021 The operand, funct3, and result registers SHALL NOT change during CALC regardless of input activity.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge, suppress done, and leave result unchanged.
REQ-023 flush and start asserted together in IDLE: flush SHALL win and no operation starts.
REQ-024 start in the DONE cycle SHALL be ignored; a new operation is accepted the following cycle (IDLE).
REQ-025 result SHALL hold its value between done pulses.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, result=0, counter=0, operand registers=0, independent of clk.
REQ-027 Reset asserted mid-CALC SHALL abandon the operation, with no done after release.
REQ-028 After rst_n deasserts, start SHALL be accepted on the first rising edge.

Verification
REQ-029 MUL, dataA=7, dataB=FFFFFFFD (-3) -> result FFFFFFEB, done on the 33rd edge, busy high 33 cycles.
REQ-030 MULHU, FFFFFFFF x FFFFFFFF -> result FFFFFFFE; MULH with the same operands -> 00000000.
REQ-031 DIV, FFFFFFF9 (-7) / 2 -> result FFFFFFFD; REM with the same operands -> FFFFFFFF; DIVU 00000064 / 00000007 -> 0000000E.
REQ-032 DIVU, 00000005 / 0 -> result FFFFFFFF with done 1 cycle after start; REM 00000005 / 0 -> 00000005; DIV 80000000 / FFFFFFFF -> 80000000.
REQ-033 Start MUL 3x4, then assert flush at cycle 10 -> no done, busy low next cycle, result keeps prior value; a second start in CALC is ignored.
REQ-034 Assert rst_n=0 mid-CALC -> busy, done, and result go 0 asynchronously; MUL 2x3 after release -> result 00000006 at cycle 33.

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu: iterative RISC-V M-extension multiply/divide unit.
// Multiplies with radix-2 shift-add and divides with restoring division.
// Both run on operand magnitudes and fix the sign in the last CALC cycle.
// Divide-by-zero and signed overflow skip the iterations and finish in one cycle.
module ex_mdu #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] dataA,
   input  logic [XLEN-1:0] dataB,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q;
   logic [2:0]        funct3_q;
   logic [XLEN-1:0]   opA_q;
   logic [XLEN-1:0]   opB_q;
   logic [XLEN-1:0]   hi_q;
   logic [XLEN-1:0]   lo_q;
   logic [XLEN-1:0]   result_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic              done_q;

   logic              aNeg;
   logic              bNeg;
   logic              isDiv;
   logic              firstStep;
   logic [XLEN-1:0]   magA;
   logic [XLEN-1:0]   magB;
   logic [XLEN-1:0]   hiSrc;
   logic [XLEN-1:0]   loSrc;
   logic [XLEN:0]     addSum;
   logic [XLEN:0]     remShift;
   logic [XLEN:0]     remDiff;
   logic [XLEN-1:0]   hi_d;
   logic [XLEN-1:0]   lo_d;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prodSigned;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   remOut;
   logic [XLEN-1:0]   calcResult_d;
   logic              divZero;
   logic              divOvf;
   logic              specialCase_d;
   logic [XLEN-1:0]   specialResult_d;

   // An operand is negative only for ops that treat it as signed.
   assign aNeg  = ((funct3_q == F_MULH) || (funct3_q == F_MULHSU) ||
                   (funct3_q == F_DIV)  || (funct3_q == F_REM)) && opA_q[XLEN-1];
   assign bNeg  = ((funct3_q == F_MULH) || (funct3_q == F_DIV) ||
                   (funct3_q == F_REM)) && opB_q[XLEN-1];
   assign magA  = aNeg ? -opA_q : opA_q;
   assign magB  = bNeg ? -opB_q : opB_q;
   assign isDiv = funct3_q[2];

   // On the first step the working pair is seeded from the captured operand.
   // This avoids a separate load cycle.
   assign firstStep = (cnt_q == '0);
   assign hiSrc     = firstStep ? '0 : hi_q;
   assign loSrc     = firstStep ? magA : lo_q;

   // One radix-2 step: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      addSum   = {1'b0, hiSrc} + {1'b0, magB};
      remShift = {hiSrc, loSrc[XLEN-1]};
      remDiff  = remShift - {1'b0, magB};
      hi_d     = hiSrc;
      lo_d     = loSrc;
      if (isDiv) begin
         if (!remDiff[XLEN]) begin
            hi_d = remDiff[XLEN-1:0];
            lo_d = {loSrc[XLEN-2:0], 1'b1};
         end else begin
            hi_d = remShift[XLEN-1:0];
            lo_d = {loSrc[XLEN-2:0], 1'b0};
         end
      end else if (loSrc[0]) begin
         {hi_d, lo_d} = {addSum, loSrc[XLEN-1:1]};
      end else begin
         {hi_d, lo_d} = {1'b0, hiSrc, loSrc[XLEN-1:1]};
      end
   end

   // Sign correction and op selection applied to the final step's output.
   always_comb begin
      prod         = {hi_d, lo_d};
      prodSigned   = (aNeg ^ bNeg) ? -prod : prod;
      quo          = (aNeg ^ bNeg) ? -lo_d : lo_d;
      remOut       = aNeg ? -hi_d : hi_d;
      calcResult_d = prodSigned[XLEN-1:0];
      case (funct3_q)
         F_MULH, F_MULHSU, F_MULHU: calcResult_d = prodSigned[2*XLEN-1:XLEN];
         F_DIV, F_DIVU:             calcResult_d = quo;
         F_REM, F_REMU:             calcResult_d = remOut;
         default:                   calcResult_d = prodSigned[XLEN-1:0];
      endcase
   end

   // Divide corner cases are resolved straight from the request inputs.
   always_comb begin
      divZero         = (dataB == '0);
      divOvf          = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                        (dataA == MOST_NEG) && (dataB == '1);
      specialCase_d   = funct3[2] && (divZero || divOvf);
      specialResult_d = funct3[1] ? (divZero ? dataA : '0)
                                  : (divZero ? '1 : dataA);
   end

   // Control FSM with registered busy/done/result; flush overrides every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         funct3_q <= '0;
         opA_q    <= '0;
         opB_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (flush) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  funct3_q <= funct3;
                  opA_q    <= dataA;
                  opB_q    <= dataB;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  if (specialCase_d) begin
                     result_q <= specialResult_d;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= CALC;
                  end
               end
            end
            CALC: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1)) begin
                  result_q <= calcResult_d;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule
